// File: rtl/cic_comp_fir_pkg.sv
// Shared types and coefficient table for the CIC droop-compensation FIR.
// Used by cic_comp_fir; the table length must match the top-level NTAPS.
package cic_comp_fir_pkg;

   localparam int unsigned COEF_WIDTH = 16;
   localparam int unsigned COEF_TAPS  = 16;

   typedef logic signed [COEF_WIDTH-1:0] coef_t;

   // Symmetric inverse-sinc taps; the taps sum to 32768, so the DC gain is 1.0 after a 15-bit shift.
   localparam coef_t COEF_TABLE [COEF_TAPS] = '{
      -16'sd3000,  16'sd4000, -16'sd6000,  16'sd8000,
      -16'sd10000, 16'sd12000, -16'sd14000, 16'sd25384,
       16'sd25384, -16'sd14000, 16'sd12000, -16'sd10000,
       16'sd8000, -16'sd6000,  16'sd4000, -16'sd3000
   };

   typedef enum logic [1:0] {
      IDLE,
      MAC,
      ROUND,
      OUT
   } fir_state_e;

endpackage

// File: rtl/cic_comp_round_sat.sv
// Round-half-up, arithmetic shift and width reduction of the FIR accumulator.
// Define CIC_COMP_FIR_SAT_EN to clamp out-of-range results; otherwise the low bits wrap.
module cic_comp_round_sat #(
   parameter int unsigned ACC_W     = 35,
   parameter int unsigned OUT_WIDTH = 16,
   parameter int unsigned OUT_SHIFT = 15
) (
   input  logic signed [ACC_W-1:0]     i_acc,
   output logic signed [OUT_WIDTH-1:0] o_result_c
);

   // One guard bit keeps the rounding add from overflowing.
   localparam int unsigned             EXT_W = ACC_W + 1;
   localparam logic signed [EXT_W-1:0] HALF  = EXT_W'(1) << (OUT_SHIFT - 1);

   logic signed [EXT_W-1:0] w_sum;
   logic signed [EXT_W-1:0] w_shr;

   assign w_sum = EXT_W'(i_acc) + HALF;
   assign w_shr = w_sum >>> OUT_SHIFT;

`ifdef CIC_COMP_FIR_SAT_EN
   localparam int unsigned HI_W = EXT_W - OUT_WIDTH + 1;

   logic [HI_W-1:0] w_hi;

   assign w_hi = w_shr[EXT_W-1:OUT_WIDTH-1];

   always_comb begin
      if (w_hi == '0 || w_hi == '1) begin
         o_result_c = OUT_WIDTH'(w_shr);
      end else if (w_shr[EXT_W-1]) begin
         o_result_c = {1'b1, {(OUT_WIDTH-1){1'b0}}};
      end else begin
         o_result_c = {1'b0, {(OUT_WIDTH-1){1'b1}}};
      end
   end
`else
   assign o_result_c = OUT_WIDTH'(w_shr);
`endif

endmodule

// File: rtl/cic_comp_fir.sv
// Sequential-MAC CIC droop-compensation FIR with a valid/ready output and a 1-entry input hold.
// Build with CIC_COMP_FIR_SAT_EN defined to saturate the output instead of wrapping it.
module cic_comp_fir
   import cic_comp_fir_pkg::*;
#(
   parameter int unsigned IN_WIDTH  = 15,
   parameter int unsigned OUT_WIDTH = 16,
   parameter int unsigned NTAPS     = 16,
   parameter int unsigned OUT_SHIFT = 15
) (
   input  logic                        clk,
   input  logic                        sys_rst_n,
   input  logic                        clk_enable,
   input  logic                        ce_in,
   input  logic signed [IN_WIDTH-1:0]  filter_in,
   output logic signed [OUT_WIDTH-1:0] filter_out,
   output logic                        valid_out,
   input  logic                        ready_in,
   output logic                        busy,
   output logic                        overrun
);

   localparam int unsigned      PTR_W    = $clog2(NTAPS);
   localparam int unsigned      PROD_W   = IN_WIDTH + COEF_WIDTH;
   localparam int unsigned      ACC_W    = PROD_W + $clog2(NTAPS);
   localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(NTAPS - 1);

   logic [1:0]                  r_rst_sync;
   logic                        w_rst_n;
   fir_state_e                  r_state;
   fir_state_e                  w_state_nxt;
   logic                        w_start;
   logic                        w_last_tap;
   logic signed [IN_WIDTH-1:0]  r_line [NTAPS];
   logic signed [IN_WIDTH-1:0]  r_hold;
   logic                        r_hold_v;
   logic [PTR_W-1:0]            r_wptr;
   logic [PTR_W-1:0]            r_rptr;
   logic [PTR_W-1:0]            r_tap;
   logic signed [IN_WIDTH-1:0]  w_x;
   logic signed [COEF_WIDTH-1:0] w_c;
   logic signed [PROD_W-1:0]    w_prod;
   logic signed [ACC_W-1:0]     r_acc;
   logic signed [OUT_WIDTH-1:0] w_rounded;
   logic signed [OUT_WIDTH-1:0] r_filter_out;
   logic                        r_valid;
   logic                        r_busy;
   logic                        r_overrun;

   // Reset asserts asynchronously and releases on a clock edge.
   always_ff @(posedge clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         r_rst_sync <= 2'b00;
      end else begin
         r_rst_sync <= {r_rst_sync[0], 1'b1};
      end
   end

   assign w_rst_n = r_rst_sync[1];

   always_ff @(posedge clk or negedge w_rst_n) begin
      if (!w_rst_n) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // A held sample takes priority over a fresh ce_in when leaving IDLE.
   always_comb begin
      w_state_nxt = r_state;
      w_start     = 1'b0;
      w_last_tap  = (r_tap == LAST_IDX);
      if (clk_enable) begin
         case (r_state)
            IDLE: begin
               if (r_hold_v || ce_in) begin
                  w_start     = 1'b1;
                  w_state_nxt = MAC;
               end
            end
            MAC:     if (w_last_tap) w_state_nxt = ROUND;
            ROUND:   w_state_nxt = OUT;
            OUT:     if (ready_in) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
         endcase
      end
   end

   assign w_x    = r_line[r_rptr];
   assign w_c    = COEF_TABLE[r_tap];
   assign w_prod = PROD_W'(w_x) * PROD_W'(w_c);

   // Delay line write and MAC walk: read pointer steps back from the newest sample.
   always_ff @(posedge clk or negedge w_rst_n) begin
      if (!w_rst_n) begin
         for (int i = 0; i < int'(NTAPS); i++) begin
            r_line[i] <= '0;
         end
         r_wptr <= '0;
         r_rptr <= '0;
         r_tap  <= '0;
         r_acc  <= '0;
      end else if (clk_enable) begin
         if (w_start) begin
            r_line[r_wptr] <= r_hold_v ? r_hold : filter_in;
            r_rptr         <= r_wptr;
            r_wptr         <= (r_wptr == LAST_IDX) ? '0 : r_wptr + 1'b1;
            r_tap          <= '0;
            r_acc          <= '0;
         end else if (r_state == MAC) begin
            r_acc  <= r_acc + ACC_W'(w_prod);
            r_tap  <= r_tap + 1'b1;
            r_rptr <= (r_rptr == '0) ? LAST_IDX : r_rptr - 1'b1;
         end
      end
   end

   // Input hold, overrun flag and output register.
   always_ff @(posedge clk or negedge w_rst_n) begin
      if (!w_rst_n) begin
         r_hold       <= '0;
         r_hold_v     <= 1'b0;
         r_overrun    <= 1'b0;
         r_filter_out <= '0;
         r_valid      <= 1'b0;
         r_busy       <= 1'b0;
      end else if (clk_enable) begin
         if (r_state == IDLE) begin
            if (r_hold_v) begin
               r_hold_v <= ce_in;
               if (ce_in) r_hold <= filter_in;
            end
         end else if (ce_in) begin
            if (r_hold_v) begin
               r_overrun <= 1'b1;
            end else begin
               r_hold   <= filter_in;
               r_hold_v <= 1'b1;
            end
         end
         if (r_state == ROUND) begin
            r_filter_out <= w_rounded;
            r_valid      <= 1'b1;
         end else if (r_state == OUT && ready_in) begin
            r_valid <= 1'b0;
         end
         r_busy <= (w_state_nxt != IDLE);
      end
   end

   cic_comp_round_sat #(
      .ACC_W     (ACC_W),
      .OUT_WIDTH (OUT_WIDTH),
      .OUT_SHIFT (OUT_SHIFT)
   ) u_round (
      .i_acc      (r_acc),
      .o_result_c (w_rounded)
   );

   assign filter_out = r_filter_out;
   assign valid_out  = r_valid;
   assign busy       = r_busy;
   assign overrun    = r_overrun;

endmodule

// File: tb/tb_cic_comp_fir.sv
// Directed and randomized bench for cic_comp_fir against a convolution reference model.
// Honors CIC_COMP_FIR_SAT_EN to pick saturating or wrapping expectations.
`timescale 1ns/1ps
module tb_cic_comp_fir;

   localparam int IN_W  = 15;
   localparam int OUT_W = 16;
   localparam int NT    = 16;
   localparam longint C [NT] = '{-3000, 4000, -6000, 8000, -10000, 12000, -14000, 25384,
                                 25384, -14000, 12000, -10000, 8000, -6000, 4000, -3000};
`ifdef CIC_COMP_FIR_SAT_EN
   localparam longint NYQ8 = 32767;
`else
   localparam longint NYQ8 = -24346;
`endif

   logic                    clk = 1'b0;
   logic                    sys_rst_n = 1'b0;
   logic                    clk_enable = 1'b1;
   logic                    ce_in = 1'b0;
   logic                    ready_in = 1'b1;
   logic signed [IN_W-1:0]  filter_in = '0;
   logic signed [OUT_W-1:0] filter_out;
   logic                    valid_out;
   logic                    busy;
   logic                    overrun;

   int     n_checks = 0;
   int     n_fail   = 0;
   longint hist[$];
   longint exp_q[$];
   longint obs_q[$];
   bit     rand_ready = 1'b0;
   int     low_run = 0;

   cic_comp_fir dut (
      .clk        (clk),
      .sys_rst_n  (sys_rst_n),
      .clk_enable (clk_enable),
      .ce_in      (ce_in),
      .filter_in  (filter_in),
      .filter_out (filter_out),
      .valid_out  (valid_out),
      .ready_in   (ready_in),
      .busy       (busy),
      .overrun    (overrun)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic signed [63:0] obs, input logic signed [63:0] expv);
      n_checks++;
      assert (obs === expv) else begin
         n_fail++;
         $error("FAIL %s: observed %0d, expected %0d", tag, obs, expv);
      end
   endtask

   function automatic longint fit(input longint y);
`ifdef CIC_COMP_FIR_SAT_EN
      if (y > 32767) return 32767;
      if (y < -32768) return -32768;
      return y;
`else
      longint m;
      m = (y + 32768) % 65536;
      if (m < 0) m += 65536;
      return m - 32768;
`endif
   endfunction

   // y[n] = sum_k x[n-k]*c[k], rounded half-up and scaled by 2^-15.
   function automatic longint ref_y();
      longint acc = 0;
      for (int k = 0; k < NT && k < hist.size(); k++) acc += hist[k] * C[k];
      return fit((acc + 16384) >>> 15);
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
      if (rand_ready) begin
         if (low_run >= 8 || $urandom_range(0, 1) == 1) begin
            ready_in = 1'b1;
            low_run  = 0;
         end else begin
            ready_in = 1'b0;
            low_run++;
         end
      end
   endtask

   task automatic send(input longint x, input bit accepted);
      ce_in     = 1'b1;
      filter_in = IN_W'(x);
      tick();
      ce_in = 1'b0;
      if (accepted) begin
         hist.push_front(x);
         exp_q.push_back(ref_y());
      end
   endtask

   task automatic wait_drain();
      int n = 0;
      while ((exp_q.size() != 0 || busy) && n < 400) begin
         tick();
         n++;
      end
      check("drain_pending", exp_q.size(), 0);
   endtask

   function automatic longint rnd_sample();
      return longint'($urandom_range(0, 32767)) - 16384;
   endfunction

   // Output monitor: scoreboard on each handshake, stability while stalled.
   logic signed [OUT_W-1:0] prev_out;
   bit                      prev_stall = 1'b0;
   always @(negedge clk) begin
      if (!sys_rst_n) begin
         prev_stall = 1'b0;
      end else begin
         if (prev_stall) begin
            check("stall_valid", valid_out, 1);
            check("stall_data", filter_out, prev_out);
         end
         if (valid_out && ready_in && clk_enable) begin
            obs_q.push_back(filter_out);
            check("spurious_output", (exp_q.size() == 0), 0);
            if (exp_q.size() != 0) check("filter_out", filter_out, exp_q.pop_front());
         end
         prev_stall = valid_out && !ready_in;
         prev_out   = filter_out;
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int     base;
      int     cyc;
      longint sum;
      bit     seen;

      repeat (3) @(posedge clk);
      #1;
      check("rst_filter_out", filter_out, 0);
      check("rst_valid", valid_out, 0);
      check("rst_busy", busy, 0);
      check("rst_overrun", overrun, 0);
      sys_rst_n = 1'b1;
      repeat (4) tick();

      // Impulse response.
      base = obs_q.size();
      send(1000, 1'b1);
      repeat (39) tick();
      for (int i = 0; i < 15; i++) begin
         send(0, 1'b1);
         repeat (39) tick();
      end
      wait_drain();
      check("impulse_count", obs_q.size() - base, 16);
      sum = 0;
      for (int i = base; i < obs_q.size(); i++) sum += obs_q[i];
      check("impulse_sum_near_1000", (sum >= 992 && sum <= 1008), 1);

      // DC settling and latency.
      send(16383, 1'b1);
      cyc = 1;
      while (!valid_out && cyc < 100) begin
         tick();
         cyc++;
      end
      check("latency", cyc, 18);
      repeat (7) tick();
      for (int i = 0; i < 19; i++) begin
         send(16383, 1'b1);
         repeat (24) tick();
      end
      wait_drain();
      check("dc_settled", obs_q[obs_q.size() - 1], 16383);

      // Backpressure: second sample held, third dropped.
      check("overrun_before", overrun, 0);
      base     = obs_q.size();
      ready_in = 1'b0;
      send(rnd_sample(), 1'b1);
      repeat (19) tick();
      send(rnd_sample(), 1'b1);
      repeat (19) tick();
      send(rnd_sample(), 1'b0);
      check("overrun_set", overrun, 1);
      repeat (9) tick();
      ready_in = 1'b1;
      wait_drain();
      check("backpressure_count", obs_q.size() - base, 2);

      // Reset during MAC.
      send(12345, 1'b1);
      repeat (5) tick();
      check("busy_mid_mac", busy, 1);
      sys_rst_n = 1'b0;
      #1;
      check("midrst_filter_out", filter_out, 0);
      check("midrst_valid", valid_out, 0);
      check("midrst_busy", busy, 0);
      check("midrst_overrun", overrun, 0);
      hist.delete();
      exp_q.delete();
      repeat (3) tick();
      sys_rst_n = 1'b1;
      seen = 1'b0;
      for (int i = 0; i < 40; i++) begin
         tick();
         seen |= valid_out;
      end
      check("no_valid_after_reset", seen, 0);

      // Nyquist-rate input from a cleared delay line.
      base = obs_q.size();
      for (int i = 0; i < 20; i++) begin
         send((i % 2 == 0) ? 16383 : -16384, 1'b1);
         repeat (24) tick();
      end
      wait_drain();
      check("nyquist_8th", obs_q[base + 7], NYQ8);

      // clk_enable stall mid-MAC, with an ignored ce_in during the stall.
      send(rnd_sample(), 1'b1);
      cyc = 1;
      while (!valid_out && cyc < 100) begin
         if (cyc == 5) clk_enable = 1'b0;
         if (cyc == 7) begin
            ce_in     = 1'b1;
            filter_in = IN_W'(rnd_sample());
         end
         if (cyc == 8) ce_in = 1'b0;
         if (cyc == 15) clk_enable = 1'b1;
         tick();
         cyc++;
      end
      check("stall_latency", cyc, 28);
      wait_drain();

      // Random samples with random (bounded) backpressure.
      rand_ready = 1'b1;
      for (int i = 0; i < 20; i++) begin
         send(rnd_sample(), 1'b1);
         repeat (39) tick();
      end
      rand_ready = 1'b0;
      ready_in   = 1'b1;
      wait_drain();
      check("overrun_final", overrun, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
